// File: rtl/pa_fdsu_srt_post.sv
// FDSU divide/sqrt back end: radix-2 restoring recurrence followed by round,
// range check and pack of an IEEE-754 single result, handed off via valid/ready.
module pa_fdsu_srt_post #(
  parameter int DIV_ITER  = 27,
  parameter int SQRT_ITER = 25,
  parameter int EXP_W     = 13
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             ex1_start,
  input  logic             ex1_div,
  input  logic             ex1_sqrt,
  input  logic [23:0]      ex1_dividend_mant,
  input  logic [23:0]      ex1_divisor,
  input  logic [EXP_W-1:0] ex1_expnt_adder_op0,
  input  logic [EXP_W-1:0] ex1_expnt_adder_op1,
  input  logic             ex1_result_sign,
  input  logic [2:0]       ex1_rm,
  input  logic             ex1_flush,
  output logic             fdsu_busy,
  output logic             fdsu_result_vld,
  input  logic             fdsu_result_rdy,
  output logic [31:0]      fdsu_result,
  output logic [2:0]       fdsu_fflags
);

  // state | meaning
  // IDLE  | waiting for start
  // ITER  | one quotient/root bit per cycle
  // RND   | round, range check, pack into result registers
  // DONE  | result_vld held until writeback takes it
  typedef enum logic [1:0] {IDLE, ITER, RND, DONE} state_t;

  localparam logic [4:0] DIV_LAST  = 5'(DIV_ITER - 1);
  localparam logic [4:0] SQRT_LAST = 5'(SQRT_ITER - 1);

  state_t             state, state_nx;
  logic [4:0]         cnt;
  logic               op_div, sign;
  logic [2:0]         rm;
  logic [23:0]        m1;
  logic [EXP_W-1:0]   e_base;
  logic [28:0]        rem;
  logic [26:0]        q;
  logic [49:0]        x;
  logic               start_acc;
  logic [EXP_W-1:0]   u, u_half;

  assign start_acc       = (state == IDLE) & ex1_start & ~ex1_flush;
  assign fdsu_busy       = (state != IDLE);
  assign fdsu_result_vld = (state == DONE);

  // sqrt exponent is floor(u/2)+127, so the odd/even split is fixed at start
  assign u      = ex1_expnt_adder_op0 - ex1_expnt_adder_op1;
  assign u_half = {u[EXP_W-1], u[EXP_W-1:1]};

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (ex1_start) state_nx = ITER;
      ITER: if (cnt == (op_div ? DIV_LAST : SQRT_LAST)) state_nx = RND;
      RND:  state_nx = DONE;
      DONE: if (fdsu_result_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (ex1_flush) state_nx = IDLE;
  end

  // recurrence step
  logic        div_ge, sq_ge;
  logic [27:0] div_rem;
  logic [28:0] sq_rem, sq_trial, step_rem;
  logic [26:0] step_q;

  always_comb begin
    div_ge   = rem >= {5'b0, m1};
    div_rem  = div_ge ? 28'(rem - {5'b0, m1}) : rem[27:0];
    sq_rem   = {rem[26:0], x[49:48]};
    sq_trial = {q, 2'b01};
    sq_ge    = sq_rem >= sq_trial;
    step_rem = op_div ? {div_rem, 1'b0} : (sq_ge ? sq_rem - sq_trial : sq_rem);
    step_q   = {q[25:0], op_div ? div_ge : sq_ge};
  end

  // rounding and packing
  logic [23:0]      mant, mant_r;
  logic [24:0]      mant_sum;
  logic             g, s, inc, uf, of, max_fin;
  logic [EXP_W-1:0] e_pre, e_post;
  logic [31:0]      rnd_result;
  logic [2:0]       rnd_flags;

  always_comb begin
    if (op_div && q[26]) begin
      mant = q[26:3]; g = q[2]; s = (|q[1:0]) | (|rem);
    end else if (op_div) begin
      mant = q[25:2]; g = q[1]; s = q[0] | (|rem);
    end else begin
      mant = q[24:1]; g = q[0]; s = |rem;
    end
    case (rm)
      3'b000:  inc = g & (s | mant[0]);
      3'b010:  inc = sign & (g | s);
      3'b011:  inc = ~sign & (g | s);
      3'b100:  inc = g;
      default: inc = 1'b0;
    endcase
    e_pre    = e_base + EXP_W'(op_div & q[26]);
    mant_sum = {1'b0, mant} + 25'(inc);
    mant_r   = mant_sum[24] ? 24'h800000 : mant_sum[23:0];
    e_post   = e_pre + EXP_W'(mant_sum[24]);
    uf       = e_pre[EXP_W-1] | (e_pre == '0);
    of       = ~e_post[EXP_W-1] & (e_post >= EXP_W'(255));
    max_fin  = (rm == 3'b001) | (rm > 3'b100) | ((rm == 3'b010) & ~sign) | ((rm == 3'b011) & sign);
    if (uf) begin
      rnd_result = {sign, 31'b0};
      rnd_flags  = 3'b011;
    end else if (of) begin
      rnd_result = max_fin ? {sign, 8'hFE, 23'h7FFFFF} : {sign, 8'hFF, 23'h0};
      rnd_flags  = 3'b101;
    end else begin
      rnd_result = {sign, e_post[7:0], mant_r[22:0]};
      rnd_flags  = {2'b00, g | s};
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      cnt <= '0; op_div <= 1'b0; sign <= 1'b0; rm <= '0; m1 <= '0; e_base <= '0;
      rem <= '0; q <= '0; x <= '0; fdsu_result <= '0; fdsu_fflags <= '0;
    end else begin
      if (start_acc) begin
        op_div <= ex1_div & ~ex1_sqrt;
        sign   <= ex1_result_sign;
        rm     <= ex1_rm;
        m1     <= ex1_divisor;
        cnt    <= '0;
        q      <= '0;
        rem    <= ex1_div ? {5'b0, ex1_dividend_mant} : '0;
        x      <= u[0] ? {ex1_dividend_mant, 26'b0} : {1'b0, ex1_dividend_mant, 25'b0};
        e_base <= ex1_div ? u + EXP_W'(126) : u_half + EXP_W'(127);
      end else if (state == ITER) begin
        rem <= step_rem;
        q   <= step_q;
        x   <= {x[47:0], 2'b00};
        cnt <= cnt + 5'd1;
      end
      if (ex1_flush) begin
        cnt         <= '0;
        fdsu_result <= '0;
        fdsu_fflags <= '0;
      end else if (state == RND) begin
        fdsu_result <= rnd_result;
        fdsu_fflags <= rnd_flags;
      end
    end
  end

endmodule

// File: tb/tb_pa_fdsu_srt_post.sv
// Scoreboard bench for pa_fdsu_srt_post: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_pa_fdsu_srt_post;

  logic        clk = 1'b0;
  logic        cpurst, ex1_start, ex1_div, ex1_sqrt, ex1_result_sign, ex1_flush;
  logic [23:0] ex1_dividend_mant, ex1_divisor;
  logic [12:0] ex1_expnt_adder_op0, ex1_expnt_adder_op1;
  logic [2:0]  ex1_rm;
  logic        fdsu_busy, fdsu_result_vld, fdsu_result_rdy;
  logic [31:0] fdsu_result;
  logic [2:0]  fdsu_fflags;

  always #5 clk = ~clk;

  pa_fdsu_srt_post dut (
    .forever_cpuclk(clk), .cpurst(cpurst), .ex1_start(ex1_start), .ex1_div(ex1_div),
    .ex1_sqrt(ex1_sqrt), .ex1_dividend_mant(ex1_dividend_mant), .ex1_divisor(ex1_divisor),
    .ex1_expnt_adder_op0(ex1_expnt_adder_op0), .ex1_expnt_adder_op1(ex1_expnt_adder_op1),
    .ex1_result_sign(ex1_result_sign), .ex1_rm(ex1_rm), .ex1_flush(ex1_flush),
    .fdsu_busy(fdsu_busy), .fdsu_result_vld(fdsu_result_vld), .fdsu_result_rdy(fdsu_result_rdy),
    .fdsu_result(fdsu_result), .fdsu_fflags(fdsu_fflags)
  );

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0;
  bit   rdy_rand = 1'b0;
  logic rdy_force = 1'b1;
  logic prev_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    fdsu_result_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic longint isqrt(input longint n);
    longint lo = 0, hi = 64'sd1 << 26, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic void model(input bit div, input logic [23:0] m0, input logic [23:0] m1,
                                input int e0, input int e1, input bit sign, input logic [2:0] rm,
                                output logic [31:0] res, output logic [2:0] flg);
    longint n, qq, rr, mant, root;
    int     e, u, odd;
    bit     g, s, inc, maxf;
    if (div) begin
      n  = longint'(m0) << 26;
      qq = n / longint'(m1);
      rr = n % longint'(m1);
      if (qq >= (64'sd1 << 26)) begin
        mant = qq >> 3; g = qq[2]; s = (qq[1:0] != 0) || (rr != 0); e = e0 - e1 + 127;
      end else begin
        mant = qq >> 2; g = qq[1]; s = qq[0] || (rr != 0); e = e0 - e1 + 126;
      end
    end else begin
      u    = e0 - e1;
      odd  = u & 1;
      n    = longint'(m0) << (25 + odd);
      root = isqrt(n);
      rr   = n - root * root;
      mant = root >> 1; g = root[0]; s = (rr != 0);
      e    = (u - odd) / 2 + 127;
    end
    case (rm)
      3'd0:    inc = g && (s || mant[0]);
      3'd2:    inc = sign && (g || s);
      3'd3:    inc = !sign && (g || s);
      3'd4:    inc = g;
      default: inc = 1'b0;
    endcase
    if (e <= 0) begin
      res = {sign, 31'b0}; flg = 3'b011;
    end else begin
      mant = mant + longint'(inc);
      if (mant == (64'sd1 << 24)) begin
        mant = 64'sd1 << 23; e++;
      end
      if (e >= 255) begin
        maxf = (rm == 3'd1) || (rm > 3'd4) || (rm == 3'd2 && !sign) || (rm == 3'd3 && sign);
        res  = maxf ? {sign, 31'h7F7FFFFF} : {sign, 31'h7F800000};
        flg  = 3'b101;
      end else begin
        res = {sign, 8'(e), 23'(mant)};
        flg = {2'b00, g || s};
      end
    end
  endfunction

  // monitor: latency on the rising edge of vld, value on every vld cycle, pop on handshake
  always @(negedge clk) begin
    if (cpurst) prev_vld = 1'b0;
    else begin
      if (fdsu_result_vld) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_vld actual=%h required=no_result", fdsu_result);
        end else begin
          if (!prev_vld) chk("latency", 32'(cyc - sb[0].start_cyc), 32'(sb[0].lat));
          chk(fdsu_result_rdy ? "result" : "result_hold", fdsu_result, sb[0].res);
          chk(fdsu_result_rdy ? "fflags" : "fflags_hold", 32'(fdsu_fflags), 32'(sb[0].flg));
          if (fdsu_result_rdy) void'(sb.pop_front());
        end
      end
      prev_vld = fdsu_result_vld;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fdsu_busy && n < 300) begin
      step(1); n++;
    end
    if (fdsu_busy) chk("idle_timeout", 32'(fdsu_busy), 32'd0);
  endtask

  task automatic issue(input bit div, input logic [23:0] m0, input logic [23:0] m1,
                       input int e0, input int e1, input bit sign, input logic [2:0] rm,
                       input bit push, input logic [31:0] eres, input logic [2:0] eflg);
    exp_t it;
    wait_idle();
    ex1_div = div; ex1_sqrt = !div; ex1_dividend_mant = m0; ex1_divisor = m1;
    ex1_expnt_adder_op0 = 13'(e0); ex1_expnt_adder_op1 = 13'(e1);
    ex1_result_sign = sign; ex1_rm = rm; ex1_start = 1'b1;
    if (push) begin
      it.res = eres; it.flg = eflg; it.start_cyc = cyc; it.lat = div ? 29 : 27;
      sb.push_back(it);
    end
    step(1);
    ex1_start = 1'b0;
  endtask

  task automatic fop(input bit div, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                     input logic [31:0] eres, input logic [2:0] eflg);
    issue(div, {1'b1, a[22:0]}, div ? {1'b1, b[22:0]} : 24'h800000, int'(a[30:23]),
          div ? int'(b[30:23]) : 127, div ? (a[31] ^ b[31]) : a[31], rm, 1'b1, eres, eflg);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      step(1); n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [23:0] m0, m1;
    logic [31:0] eres;
    logic [2:0]  eflg, rm;
    int          e0, e1, n;
    bit          div, sign;

    cpurst = 1'b1; ex1_start = 1'b0; ex1_div = 1'b0; ex1_sqrt = 1'b0; ex1_flush = 1'b0;
    ex1_dividend_mant = '0; ex1_divisor = '0; ex1_expnt_adder_op0 = '0; ex1_expnt_adder_op1 = '0;
    ex1_result_sign = 1'b0; ex1_rm = '0; fdsu_result_rdy = 1'b1;
    step(3);
    chk("rst_busy", 32'(fdsu_busy), 32'd0);
    chk("rst_vld", 32'(fdsu_result_vld), 32'd0);
    chk("rst_result", fdsu_result, 32'd0);
    chk("rst_fflags", 32'(fdsu_fflags), 32'd0);
    cpurst = 1'b0;
    step(1);

    fop(1, 32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 3'b000);
    fop(1, 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 3'b001);
    fop(1, 32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 3'b001);
    fop(0, 32'h40000000, 32'h0,        3'd0, 32'h3FB504F3, 3'b001);
    fop(0, 32'h40800000, 32'h0,        3'd0, 32'h40000000, 3'b000);
    fop(1, 32'h7F000000, 32'h3E800000, 3'd0, 32'h7F800000, 3'b101);
    fop(1, 32'h7F000000, 32'h3E800000, 3'd1, 32'h7F7FFFFF, 3'b101);
    fop(1, 32'h00800000, 32'h4B000000, 3'd0, 32'h00000000, 3'b011);
    fop(1, 32'h80800000, 32'h4B000000, 3'd0, 32'h80000000, 3'b011);
    drain();

    // writeback stalls for 10 cycles while start is hammered; the handshake cycle also carries start
    rdy_force = 1'b0;
    fop(1, 32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 3'b001);
    n = 0;
    while (!fdsu_result_vld && n < 100) begin
      step(1); n++;
    end
    chk("hold_vld_seen", 32'(fdsu_result_vld), 32'd1);
    ex1_start = 1'b1; ex1_div = 1'b0; ex1_sqrt = 1'b1; ex1_dividend_mant = 24'hC00000;
    step(10);
    rdy_force = 1'b1;
    step(1);
    ex1_start = 1'b0;
    step(40);
    chk("hold_no_restart", 32'(fdsu_busy), 32'd0);
    drain();

    // flush at ITER cycle 5, after an inexact result left NX in fflags
    fop(1, 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 3'b001);
    drain();
    issue(0, 24'h9A0000, 24'h800000, 130, 127, 1'b0, 3'd0, 1'b0, 32'h0, 3'b000);
    step(4);
    ex1_flush = 1'b1;
    step(1);
    ex1_flush = 1'b0;
    chk("flush_busy", 32'(fdsu_busy), 32'd0);
    chk("flush_fflags", 32'(fdsu_fflags), 32'd0);
    step(40);
    chk("flush_no_vld", 32'(fdsu_result_vld), 32'd0);

    // flush together with start
    ex1_start = 1'b1; ex1_flush = 1'b1; ex1_div = 1'b1; ex1_sqrt = 1'b0;
    step(1);
    ex1_start = 1'b0; ex1_flush = 1'b0;
    chk("flush_start_busy", 32'(fdsu_busy), 32'd0);
    step(35);
    chk("flush_start_no_vld", 32'(fdsu_result_vld), 32'd0);

    // reset in the middle of an operation
    fop(1, 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 3'b001);
    drain();
    issue(1, 24'hF00000, 24'h900000, 140, 120, 1'b1, 3'd0, 1'b0, 32'h0, 3'b000);
    step(8);
    cpurst = 1'b1;
    step(2);
    chk("rst_mid_busy", 32'(fdsu_busy), 32'd0);
    chk("rst_mid_result", fdsu_result, 32'd0);
    chk("rst_mid_fflags", 32'(fdsu_fflags), 32'd0);
    cpurst = 1'b0;
    step(2);

    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      div  = 1'($urandom_range(0, 1));
      m0   = {1'b1, 23'($urandom)};
      m1   = ($urandom_range(0, 3) == 0) ? m0 : {1'b1, 23'($urandom)};
      sign = 1'($urandom_range(0, 1));
      rm   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) m0 = 24'hFFFFFF;
      if (div) begin
        e0 = int'($urandom_range(60, 200));
        e1 = int'($urandom_range(60, 200));
      end else begin
        e0 = int'($urandom_range(0, 276)) - 22;
        e1 = 127;
      end
      model(div, m0, m1, e0, e1, sign, rm, eres, eflg);
      issue(div, m0, m1, e0, e1, sign, rm, 1'b1, eres, eflg);
    end
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    step(2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
